conv_mac_seq: RTL and testbench

Window sequencer sitting directly upstream of the 8-bit MAC/ReLU/quantize unit in the conv2d datapath. For each output pixel of a valid-padding, stride-1 KxK convolution over a CH-channel feature map, it clears the MAC and injects the bias through the MAC's add-only path. It then streams the KxK*CH feature/weight pairs from synchronous-read buffers and captures the quantized, ReLU'd result. Results leave on a valid/ready port with the output pixel index.

---
 rtl/conv_mac_seq.sv | 183 ++++++++++++++++++
 tb/tb_conv_mac_seq.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_mac_seq.sv
// Window sequencer for a valid-padding, stride-1 KxK conv2d feeding an 8-bit MAC/ReLU/quantize unit.
// Per output pixel: clear MAC, inject bias via add-only path, stream K*K*CH taps, capture, emit.
module conv_mac_seq #(
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int K      = 3,
    parameter int CH     = 1,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        bias,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] f_addr,
    input  logic [7:0]        f_rdata,
    output logic [ADDR_W-1:0] w_addr,
    input  logic [7:0]        w_rdata,
    output logic              mac_clr_n,
    output logic              mac_enable,
    output logic              mac_only_add,
    output logic [7:0]        mac_din_a,
    output logic [7:0]        mac_din_b,
    input  logic [7:0]        mac_dout,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_data,
    output logic [ADDR_W-1:0] out_addr
);
    localparam int OW = IMG_W - K + 1;
    localparam int OH = IMG_H - K + 1;
    localparam int N  = K * K * CH;

    localparam logic [ADDR_W-1:0] K_A     = ADDR_W'(K);
    localparam logic [ADDR_W-1:0] N_A     = ADDR_W'(N);
    localparam logic [ADDR_W-1:0] OW_A    = ADDR_W'(OW);
    localparam logic [ADDR_W-1:0] OH_A    = ADDR_W'(OH);
    localparam logic [ADDR_W-1:0] IMG_W_A = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] PLANE_A = ADDR_W'(IMG_W * IMG_H);

    typedef enum logic [2:0] {
        IDLE, CLEAR, BIAS, MAC, DRAIN, CAPT, OUT, DONE
    } state_t;

    state_t            state_q;
    logic              busy_q, done_q, clr_n_q, en_q, only_add_q, out_valid_q;
    logic [7:0]        bias_q, out_data_q;
    logic [ADDR_W-1:0] f_addr_q, w_addr_q, out_addr_q;
    logic [ADDR_W-1:0] t_q, kx_q, ky_q, c_q, ox_q, oy_q;

    logic [ADDR_W-1:0] kx_d, ky_d, c_d, tap_addr_d, base_addr_d, px_addr_d;
    logic              last_px;

    // Next tap position, kx fastest, then ky, then channel.
    always_comb begin
        kx_d = kx_q + 1'b1;
        ky_d = ky_q;
        c_d  = c_q;
        if (kx_q == K_A - 1'b1) begin
            kx_d = '0;
            ky_d = ky_q + 1'b1;
            if (ky_q == K_A - 1'b1) begin
                ky_d = '0;
                c_d  = c_q + 1'b1;
            end
        end
    end

    assign tap_addr_d  = c_d * PLANE_A + (oy_q + ky_d) * IMG_W_A + ox_q + kx_d;
    assign base_addr_d = oy_q * IMG_W_A + ox_q;
    assign px_addr_d   = oy_q * OW_A + ox_q;
    assign last_px     = (ox_q == OW_A - 1'b1) && (oy_q == OH_A - 1'b1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            clr_n_q     <= 1'b0;
            en_q        <= 1'b0;
            only_add_q  <= 1'b0;
            out_valid_q <= 1'b0;
            bias_q      <= '0;
            out_data_q  <= '0;
            f_addr_q    <= '0;
            w_addr_q    <= '0;
            out_addr_q  <= '0;
            t_q         <= '0;
            kx_q        <= '0;
            ky_q        <= '0;
            c_q         <= '0;
            ox_q        <= '0;
            oy_q        <= '0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    bias_q  <= bias;
                    ox_q    <= '0;
                    oy_q    <= '0;
                    busy_q  <= 1'b1;
                    state_q <= CLEAR;
                end
                CLEAR: begin
                    clr_n_q    <= 1'b1;
                    en_q       <= 1'b1;
                    only_add_q <= 1'b1;
                    state_q    <= BIAS;
                end
                BIAS: begin
                    en_q       <= 1'b0;
                    only_add_q <= 1'b0;
                    t_q        <= '0;
                    kx_q       <= '0;
                    ky_q       <= '0;
                    c_q        <= '0;
                    f_addr_q   <= base_addr_d;
                    w_addr_q   <= '0;
                    state_q    <= MAC;
                end
                MAC: begin
                    // Enable trails the address by one cycle to match the buffer read latency.
                    en_q <= 1'b1;
                    if (t_q == N_A - 1'b1) begin
                        state_q <= DRAIN;
                    end else begin
                        t_q      <= t_q + 1'b1;
                        kx_q     <= kx_d;
                        ky_q     <= ky_d;
                        c_q      <= c_d;
                        f_addr_q <= tap_addr_d;
                        w_addr_q <= t_q + 1'b1;
                    end
                end
                DRAIN: begin
                    en_q    <= 1'b0;
                    state_q <= CAPT;
                end
                CAPT: begin
                    out_data_q  <= mac_dout;
                    out_addr_q  <= px_addr_d;
                    out_valid_q <= 1'b1;
                    state_q     <= OUT;
                end
                OUT: if (out_ready) begin
                    out_valid_q <= 1'b0;
                    clr_n_q     <= 1'b0;
                    if (last_px) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        if (ox_q == OW_A - 1'b1) begin
                            ox_q <= '0;
                            oy_q <= oy_q + 1'b1;
                        end else begin
                            ox_q <= ox_q + 1'b1;
                        end
                        state_q <= CLEAR;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign f_addr       = f_addr_q;
    assign w_addr       = w_addr_q;
    assign mac_clr_n    = clr_n_q;
    assign mac_enable   = en_q;
    assign mac_only_add = only_add_q;
    assign mac_din_a    = only_add_q ? bias_q : (en_q ? f_rdata : 8'd0);
    assign mac_din_b    = (en_q && !only_add_q) ? w_rdata : 8'd0;
    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_addr     = out_addr_q;
endmodule

// File: tb/tb_conv_mac_seq.sv
// Bench for conv_mac_seq on a 4x4 image, 3x3 kernel: models the buffers and the MAC,
// checks every emitted pixel against a queue of expected {addr, data} results.
module tb_conv_mac_seq;
    localparam int IMG_W = 4, IMG_H = 4, K = 3, CH = 1, ADDR_W = 10;
    localparam int OW = IMG_W - K + 1;
    localparam int NPX = OW * (IMG_H - K + 1);
    localparam int W = ADDR_W + 8;

    logic              clk = 0;
    logic              rst, start, out_ready;
    logic [7:0]        bias;
    logic              busy, done, mac_clr_n, mac_enable, mac_only_add, out_valid;
    logic [ADDR_W-1:0] f_addr, w_addr, out_addr;
    logic [7:0]        f_rdata, w_rdata, mac_din_a, mac_din_b, mac_dout, out_data;

    logic signed [7:0] fmem [0:63];
    logic signed [7:0] wmem [0:63];
    int                acc;
    logic [W-1:0]      exp_q[$];
    int                n_cmp = 0, n_fail = 0;
    int                px_cnt = 0;

    typedef struct { int f; int w; int b; int exp_d; } vec_t;
    vec_t vt [4];

    conv_mac_seq #(.IMG_W(IMG_W), .IMG_H(IMG_H), .K(K), .CH(CH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .start(start), .bias(bias), .busy(busy), .done(done),
        .f_addr(f_addr), .f_rdata(f_rdata), .w_addr(w_addr), .w_rdata(w_rdata),
        .mac_clr_n(mac_clr_n), .mac_enable(mac_enable), .mac_only_add(mac_only_add),
        .mac_din_a(mac_din_a), .mac_din_b(mac_din_b), .mac_dout(mac_dout),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr)
    );

    // clock / reset-independent models of buffers and MAC
    always #5 clk = ~clk;

    always @(posedge clk) begin
        f_rdata <= fmem[f_addr[5:0]];
        w_rdata <= wmem[w_addr[5:0]];
    end

    always @(posedge clk) begin
        if (!mac_clr_n) acc <= 0;
        else if (mac_enable)
            acc <= acc + (mac_only_add ? int'($signed(mac_din_a)) * 256
                                       : int'($signed(mac_din_a)) * int'($signed(mac_din_b)));
    end

    always_comb begin
        int q;
        q = acc >>> 8;
        if (q < 0) mac_dout = 8'd0;
        else if (q > 127) mac_dout = 8'd127;
        else mac_dout = 8'(q);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
        end
    endtask

    function automatic int calc_px(input int p, input int b);
        int a, q, ox, oy;
        ox = p % OW;
        oy = p / OW;
        a = b * 256;
        for (int ky = 0; ky < K; ky++)
            for (int kx = 0; kx < K; kx++)
                a += int'(fmem[(oy + ky) * IMG_W + ox + kx]) * int'(wmem[ky * K + kx]);
        q = a >>> 8;
        if (q < 0) q = 0;
        if (q > 127) q = 127;
        return q;
    endfunction

    task automatic fill(input int f, input int w);
        for (int i = 0; i < 64; i++) begin
            fmem[i] = 8'(f);
            wmem[i] = 8'(w);
        end
    endtask

    task automatic push_all(input int b);
        for (int p = 0; p < NPX; p++)
            exp_q.push_back({ADDR_W'(p), 8'(calc_px(p, b))});
    endtask

    task automatic run_pass(input int b, input int exp_cyc);
        int cyc;
        bit got;
        px_cnt = 0;
        @(posedge clk); #1 start = 1; bias = 8'(b);
        @(posedge clk); #1 start = 0;
        cyc = 0;
        got = 0;
        for (int i = 0; i < 2000 && !got; i++) begin
            @(negedge clk);
            cyc++;
            if (done) got = 1;
        end
        chk("done_seen", got, 1);
        chk("pass_cycles", cyc, exp_cyc);
    endtask

    // scoreboard: pop on each handshake
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", 1, 0);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                chk("out_addr", out_addr, e[W-1:8]);
                chk("out_data", out_data, e[7:0]);
            end
        end
    end

    // First tap address and MAC controls around the bias injection
    bit arm = 0;
    int arm_px = 0;
    always @(negedge clk) begin
        if (rst) begin
            arm = 0;
        end else begin
            if (arm) begin
                arm = 0;
                chk("f_addr_tap0", f_addr, (arm_px / OW) * IMG_W + arm_px % OW);
                chk("w_addr_tap0", w_addr, 0);
                chk("en_mac0", mac_enable, 0);
            end
            if (mac_only_add) begin
                chk("bias_en", mac_enable, 1);
                chk("bias_din_b", mac_din_b, 0);
                arm = 1;
                arm_px = px_cnt;
                px_cnt++;
            end
        end
    end

    task automatic stall_proc();
        bit seen;
        logic [7:0] hold_d;
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (out_valid && out_addr == 1) seen = 1;
        end
        chk("stall_sync", seen, 1);
        @(posedge clk); #1 out_ready = 0;
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        chk("stall_valid", seen, 1);
        hold_d = out_data;
        for (int k = 1; k < 7; k++) begin
            @(negedge clk);
            chk("stall_valid_hold", out_valid, 1);
            chk("stall_data_hold", out_data, hold_d);
            chk("stall_addr_hold", out_addr, 2);
            chk("stall_enable", mac_enable, 0);
            if (k == 3) start = 1;
            if (k == 4) start = 0;
        end
        @(posedge clk); #1 out_ready = 1;
    endtask

    initial begin
        vt[0] = '{f: 16,  w: 16,  b: 0,   exp_d: 9};
        vt[1] = '{f: 16,  w: 0,   b: 5,   exp_d: 5};
        vt[2] = '{f: 16,  w: -16, b: 0,   exp_d: 0};
        vt[3] = '{f: 127, w: 127, b: 127, exp_d: 127};
        fill(0, 0);

        rst = 1; start = 1; bias = 8'd33; out_ready = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_clr_n", mac_clr_n, 0);
        chk("rst_enable", mac_enable, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_f_addr", f_addr, 0);
        rst = 0; start = 0;
        repeat (2) @(negedge clk);
        chk("start_during_rst", busy, 0);

        for (int i = 0; i < 4; i++) begin
            fill(vt[i].f, vt[i].w);
            for (int p = 0; p < NPX; p++)
                exp_q.push_back({ADDR_W'(p), 8'(vt[i].exp_d)});
            run_pass(vt[i].b, 57);
            chk("queue_empty_tbl", exp_q.size(), 0);
        end

        for (int i = 0; i < 64; i++) begin
            fmem[i] = 8'($urandom_range(0, 80) - 40);
            wmem[i] = 8'($urandom_range(0, 60) - 30);
        end
        begin
            int rb;
            rb = $urandom_range(0, 60) - 30;
            push_all(rb);
            run_pass(rb, 57);
        end
        chk("queue_empty_rand", exp_q.size(), 0);

        fill(16, 16);
        push_all(0);
        fork
            run_pass(0, 64);
            stall_proc();
        join
        chk("queue_empty_stall", exp_q.size(), 0);
        repeat (3) @(negedge clk);
        chk("start_midpass_ignored", busy, 0);

        begin
            bit seen;
            exp_q.push_back({ADDR_W'(0), 8'd9});
            px_cnt = 0;
            @(posedge clk); #1 start = 1; bias = 8'd0;
            @(posedge clk); #1 start = 0;
            seen = 0;
            for (int i = 0; i < 200 && !seen; i++) begin
                @(negedge clk);
                if (out_valid) seen = 1;
            end
            chk("rst_mid_sync", seen, 1);
            repeat (5) @(posedge clk);
            #1 rst = 1;
            @(negedge clk);
            chk("mid_rst_busy", busy, 0);
            chk("mid_rst_clr_n", mac_clr_n, 0);
            chk("mid_rst_out_valid", out_valid, 0);
            chk("mid_rst_enable", mac_enable, 0);
            @(posedge clk); #1 rst = 0;
            chk("queue_empty_rst", exp_q.size(), 0);
        end
        push_all(0);
        run_pass(0, 57);
        chk("queue_empty_final", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
